softmax_rd_req: RTL and testbench
=================================

# softmax_rd_req

Read-request generator for the softmax path. On `start` it issues AXI burst read requests to the MCIF for the input feature map. The request order is exactly the order in which the downstream buffer-writer stage consumes responses: per line `h`, per W-burst, three softmax passes (max, exp-sum, normalise), per channel group. Outstanding response data is bounded by a pixel-credit counter that mirrors the response FIFO depth, so the response FIFO never overflows.

## Interface
- `AW`, 32: byte address width.
- `AXI_BURST_LEN`, 16: pixels per full burst. Power of two.
- `LOG2_BURST`, 4: log2 of `AXI_BURST_LEN`.
- `TOUT`, 32: channels per pixel word.
- `MAX_DAT_DW`, 8: bits per channel.
- `FIFO_DEPTH`, 64: response FIFO depth in pixels. Must be ≥ `AXI_BURST_LEN`.
- `LOG2_CH`, `LOG2_H`, `LOG2_W`, 12: counter widths.

- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle launch pulse from the CSR.
- `base_addr`  in  AW: byte address of channel group 0, line 0, pixel 0.
- `surface_stride`  in  AW: byte step between channel groups.
- `line_stride`  in  AW: byte step between lines.
- `ch_in_div_tout`  in  LOG2_CH: number of channel groups. ≥1.
- `h_in`  in  LOG2_H: lines. ≥1.
- `w_in`  in  LOG2_W: pixels per line. ≥1.
- `rd_req_vld`  out  1: request valid.
- `rd_req_rdy`  in  1: MCIF accepts the request.
- `rd_req_addr`  out  AW: burst start byte address.
- `rd_req_len`  out  LOG2_BURST: burst pixel count minus 1.
- `rd_fifo_pop`  in  1: one pixel left the response FIFO. Driven by the downstream stage.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle pulse when the frame is complete and drained.

## Operation
- Counters, innermost first:
  - `ch` runs 0..`ch_in_div_tout`-1.
  - `cyc` runs 0..2.
  - `wb` runs 0..((`w_in`-1)>>`LOG2_BURST`).
  - `h` runs 0..`h_in`-1.
- Each counter advances only when a request handshake (`rd_req_vld & rd_req_rdy`) occurs and all inner counters are at max.
- `rd_req_len`:
  - `AXI_BURST_LEN`-1 for every burst except the last in a line.
  - For the last burst in a line: `w_in[LOG2_BURST-1:0]`-1, which wraps to `AXI_BURST_LEN`-1 when `w_in` is a multiple of the burst length.
- Address:
  - `rd_req_addr` = `base_addr` + `ch`·`surface_stride` + `h`·`line_stride` + `wb`·`AXI_BURST_LEN`·PIX_BYTES.
  - PIX_BYTES = `TOUT`·`MAX_DAT_DW`/8.
  - Implemented with accumulators (line base, burst base, channel offset), not multipliers. Arithmetic is modulo 2^AW.
- Credit counter:
  - Width is log2(`FIFO_DEPTH`)+1. Reset value is `FIFO_DEPTH`.
  - On a request handshake, subtract `rd_req_len`+1.
  - Add 1 on each `rd_fifo_pop`.
  - When a handshake and a pop fall in the same cycle, apply the net change.
  - The counter never exceeds `FIFO_DEPTH`; a pop while the counter is full is a protocol error and is flagged by a bench assertion.
- FSM:
  - IDLE: `start` → ISSUE, and all counters/accumulators load from the CSR inputs.
  - ISSUE: `rd_req_vld` = (credit ≥ `rd_req_len`+1). A handshake on the last request (all counters at max) → DRAIN.
  - DRAIN: credit == `FIFO_DEPTH` → IDLE, with `done`=1 for that one cycle.
- `start` outside IDLE is ignored.
- `busy` = state ≠ IDLE.
- CSR inputs are sampled at `start` only. Changes mid-frame have no effect.

## Timing
- Reset values:
  - `rd_req_vld`=0, `rd_req_addr`=0, `rd_req_len`=0, `busy`=0, `done`=0.
  - State is IDLE and all counters are 0.
- The first request appears at the earliest 1 cycle after `start`.
- Back-to-back issue: one request per cycle while `rd_req_rdy`=1 and credit allows.
- Once `rd_req_vld` is asserted, it and `rd_req_addr`/`rd_req_len` stay stable until the handshake. Credit only grows while a request waits, so `rd_req_vld` never drops.
- All outputs are registered.
- `done` fires in the cycle after the pop that restores full credit.
- Asserting `rst_n` mid-frame returns the block to IDLE immediately. In-flight MCIF data is the system's responsibility.

## Structure
- Shared softmax package holds:
  - PIX_BYTES.
  - The FSM state enum (IDLE/ISSUE/DRAIN).
  - The pass count constant 3. The downstream stage uses the same constant.
- One natural sub-module: `softmax_credit_cnt`, which holds the credit counter, the sufficiency compare and the full flag. Everything else stays flat.

## Test plan
- Base sequence:
  - Setup: `base`=0x1000, `surface_stride`=0x4000, `line_stride`=0x800, `h_in`=1, `w_in`=20, `ch_in_div_tout`=2, `rd_req_rdy`=1, pops supplied promptly.
  - Requests 0..5: address 0x1000/0x5000 alternating, len 15.
  - Requests 6..11: address 0x1200/0x5200 alternating, len 3.
  - Then `done`.
- Credit stall:
  - Setup: `w_in`=64, `FIFO_DEPTH`=64, no pops.
  - Exactly 4 requests are issued, then `rd_req_vld` stays 0.
  - 16 pops → exactly one further request.
- Backpressure:
  - `rd_req_rdy` held low 5 cycles.
  - `rd_req_vld`/`addr`/`len` are constant during the stall, with no duplicate or skipped request.
- Multi-line wrap:
  - `h_in`=2, `w_in`=16.
  - Line 1 requests start at `base`+`line_stride`, len 15.
  - Total requests = 2·1·3·`ch_in_div_tout`.
- Simultaneous events and ignored start:
  - Handshake (len 15) and pop in the same cycle → credit changes by -15.
  - `start` during ISSUE is ignored.
  - `done` fires only after the final pop.
- Reset mid-frame:
  - `rst_n` low during ISSUE → all outputs at reset values.
  - A new `start` reproduces the sequence from request 0.

Source files
------------

// File: rtl/softmax_rd_req_pkg.sv
// Shared softmax definitions: pixel byte size, FSM state encoding and the
// number of softmax passes per burst. The pass count is also used by the
// downstream buffer-writer stage, so both sides agree on the response order.
package softmax_rd_req_pkg;

  // Default datapath geometry of the softmax path.
  localparam int unsigned SOFTMAX_TOUT       = 32;
  localparam int unsigned SOFTMAX_MAX_DAT_DW = 8;

  // Softmax passes per burst: max, exp-sum, normalise.
  localparam int unsigned SOFTMAX_PASSES = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sm_state_e;

  // Bytes per pixel word for a given channel count and channel width.
  function automatic int unsigned pix_bytes(input int unsigned tout,
                                            input int unsigned dat_dw);
    return (tout * dat_dw) / 8;
  endfunction

  localparam int unsigned PIX_BYTES = pix_bytes(SOFTMAX_TOUT, SOFTMAX_MAX_DAT_DW);

endpackage

// File: rtl/softmax_rd_req_credit_cnt.sv
// Pixel-credit counter mirroring free space in the response FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (credit resets to FIFO_DEPTH)
//   take       : a request handshake this cycle
//   take_len   : burst length minus 1 of the request being taken
//   pop        : one pixel left the response FIFO this cycle
//   need_len   : burst length minus 1 of the request that would issue next
//   enough_nxt : next-cycle credit covers need_len+1 pixels
//   full_nxt   : next-cycle credit equals FIFO_DEPTH (nothing outstanding)
// Both flags look at the next-cycle credit so the parent can register them.
module softmax_credit_cnt #(
  parameter  int unsigned FIFO_DEPTH = 64,
  parameter  int unsigned LOG2_BURST = 4,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  take,
  input  logic [LOG2_BURST-1:0] take_len,
  input  logic                  pop,
  input  logic [LOG2_BURST-1:0] need_len,
  output logic                  enough_nxt,
  output logic                  full_nxt
);

  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;
  logic [CW-1:0] take_px;
  logic [CW-1:0] need_px;

  always_comb begin
    take_px  = {{(CW-LOG2_BURST){1'b0}}, take_len} + CW'(1);
    need_px  = {{(CW-LOG2_BURST){1'b0}}, need_len} + CW'(1);
    credit_d = credit_q;
    if (take) credit_d = credit_d - take_px;
    if (pop)  credit_d = credit_d + CW'(1);
    enough_nxt = (credit_d >= need_px);
    full_nxt   = (credit_d == CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= CW'(FIFO_DEPTH);
    else        credit_q <= credit_d;
  end

endmodule

// File: rtl/softmax_rd_req.sv
// Softmax read-request generator. On start, walks (h, W-burst, pass, channel
// group) from outermost to innermost and issues one MCIF burst read per step,
// gated by pixel credit so the response FIFO never overflows.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle launch pulse (ignored unless idle)
//   base_addr            : byte address of group 0, line 0, pixel 0
//   surface_stride       : byte step between channel groups
//   line_stride          : byte step between lines
//   ch_in_div_tout       : channel groups (>=1)
//   h_in, w_in           : lines and pixels per line (>=1)
//   rd_req_vld/rdy       : request handshake
//   rd_req_addr/len      : burst start byte address, pixel count minus 1
//   rd_fifo_pop          : one pixel consumed from the response FIFO
//   busy                 : frame in progress
//   done                 : one-cycle pulse once the frame is issued and drained
module softmax_rd_req
  import softmax_rd_req_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned AXI_BURST_LEN = 16,
  parameter int unsigned LOG2_BURST    = 4,
  parameter int unsigned TOUT          = 32,
  parameter int unsigned MAX_DAT_DW    = 8,
  parameter int unsigned FIFO_DEPTH    = 64,
  parameter int unsigned LOG2_CH       = 12,
  parameter int unsigned LOG2_H        = 12,
  parameter int unsigned LOG2_W        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW-1:0]         surface_stride,
  input  logic [AW-1:0]         line_stride,
  input  logic [LOG2_CH-1:0]    ch_in_div_tout,
  input  logic [LOG2_H-1:0]     h_in,
  input  logic [LOG2_W-1:0]     w_in,
  output logic                  rd_req_vld,
  input  logic                  rd_req_rdy,
  output logic [AW-1:0]         rd_req_addr,
  output logic [LOG2_BURST-1:0] rd_req_len,
  input  logic                  rd_fifo_pop,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned          PIX_B       = pix_bytes(TOUT, MAX_DAT_DW);
  localparam logic [AW-1:0]        BURST_BYTES = AW'(AXI_BURST_LEN * PIX_B);
  localparam logic [LOG2_BURST-1:0] FULL_LEN   = LOG2_BURST'(AXI_BURST_LEN - 1);
  localparam logic [1:0]           CYC_LAST    = 2'(SOFTMAX_PASSES - 1);

  sm_state_e             state_q, state_d;
  logic [LOG2_CH-1:0]    ch_q, ch_d, ch_max_q, ch_max_d;
  logic [1:0]            cyc_q, cyc_d;
  logic [LOG2_W-1:0]     wb_q, wb_d, wb_max_q, wb_max_d;
  logic [LOG2_H-1:0]     h_q, h_d, h_max_q, h_max_d;
  logic [LOG2_BURST-1:0] last_len_q, last_len_d;
  logic [AW-1:0]         surf_q, surf_d, lstride_q, lstride_d;
  logic [AW-1:0]         line_base_q, line_base_d;
  logic [AW-1:0]         burst_off_q, burst_off_d;
  logic [AW-1:0]         ch_off_q, ch_off_d;
  logic                  vld_q, vld_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [LOG2_BURST-1:0] len_q, len_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic hs;
  logic new_req;
  logic enough_nxt;
  logic full_nxt;

  assign hs = vld_q & rd_req_rdy;

  softmax_credit_cnt #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LOG2_BURST (LOG2_BURST)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .take       (hs),
    .take_len   (len_q),
    .pop        (rd_fifo_pop),
    .need_len   (len_d),
    .enough_nxt (enough_nxt),
    .full_nxt   (full_nxt)
  );

  // Sequencing: next state, loop counters, address accumulators, next request.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cyc_d       = cyc_q;
    wb_d        = wb_q;
    h_d         = h_q;
    ch_max_d    = ch_max_q;
    wb_max_d    = wb_max_q;
    h_max_d     = h_max_q;
    last_len_d  = last_len_q;
    surf_d      = surf_q;
    lstride_d   = lstride_q;
    line_base_d = line_base_q;
    burst_off_d = burst_off_q;
    ch_off_d    = ch_off_q;
    addr_d      = addr_q;
    len_d       = len_q;
    done_d      = 1'b0;
    new_req     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ISSUE;
          new_req     = 1'b1;
          ch_d        = '0;
          cyc_d       = '0;
          wb_d        = '0;
          h_d         = '0;
          ch_max_d    = ch_in_div_tout - LOG2_CH'(1);
          wb_max_d    = (w_in - LOG2_W'(1)) >> LOG2_BURST;
          h_max_d     = h_in - LOG2_H'(1);
          last_len_d  = w_in[LOG2_BURST-1:0] - LOG2_BURST'(1);
          surf_d      = surface_stride;
          lstride_d   = line_stride;
          line_base_d = base_addr;
          burst_off_d = '0;
          ch_off_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          new_req = 1'b1;
          // Odometer carry; each accumulator tracks counter*stride.
          if (ch_q != ch_max_q) begin
            ch_d     = ch_q + LOG2_CH'(1);
            ch_off_d = ch_off_q + surf_q;
          end else begin
            ch_d     = '0;
            ch_off_d = '0;
            if (cyc_q != CYC_LAST) begin
              cyc_d = cyc_q + 2'd1;
            end else begin
              cyc_d = '0;
              if (wb_q != wb_max_q) begin
                wb_d        = wb_q + LOG2_W'(1);
                burst_off_d = burst_off_q + BURST_BYTES;
              end else begin
                wb_d        = '0;
                burst_off_d = '0;
                if (h_q != h_max_q) begin
                  h_d         = h_q + LOG2_H'(1);
                  line_base_d = line_base_q + lstride_q;
                end else begin
                  state_d = ST_DRAIN;
                end
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        if (full_nxt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (new_req && (state_d == ST_ISSUE)) begin
      addr_d = line_base_d + burst_off_d + ch_off_d;
      len_d  = (wb_d == wb_max_d) ? last_len_d : FULL_LEN;
    end
  end

  // Valid is held while the MCIF stalls; otherwise it follows next-cycle credit.
  always_comb begin
    vld_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_ISSUE) begin
      if (vld_q && !rd_req_rdy) vld_d = 1'b1;
      else                      vld_d = enough_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      cyc_q       <= '0;
      wb_q        <= '0;
      h_q         <= '0;
      ch_max_q    <= '0;
      wb_max_q    <= '0;
      h_max_q     <= '0;
      last_len_q  <= '0;
      surf_q      <= '0;
      lstride_q   <= '0;
      line_base_q <= '0;
      burst_off_q <= '0;
      ch_off_q    <= '0;
      vld_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cyc_q       <= cyc_d;
      wb_q        <= wb_d;
      h_q         <= h_d;
      ch_max_q    <= ch_max_d;
      wb_max_q    <= wb_max_d;
      h_max_q     <= h_max_d;
      last_len_q  <= last_len_d;
      surf_q      <= surf_d;
      lstride_q   <= lstride_d;
      line_base_q <= line_base_d;
      burst_off_q <= burst_off_d;
      ch_off_q    <= ch_off_d;
      vld_q       <= vld_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_req_vld  = vld_q;
  assign rd_req_addr = addr_q;
  assign rd_req_len  = len_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_softmax_rd_req.sv
// Directed bench for softmax_rd_req. Inputs change at negedge+1 (tests) and
// negedge+2 (pop driver); handshakes are recorded at negedge+3, i.e. with the
// exact values the following posedge will see.
module tb_softmax_rd_req;

  localparam int unsigned AW            = 32;
  localparam int unsigned AXI_BURST_LEN = 16;
  localparam int unsigned LOG2_BURST    = 4;
  localparam int unsigned FIFO_DEPTH    = 64;
  localparam int unsigned CW            = 7;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [AW-1:0]         base_addr = '0;
  logic [AW-1:0]         surface_stride = '0;
  logic [AW-1:0]         line_stride = '0;
  logic [11:0]           ch_in_div_tout = 12'd1;
  logic [11:0]           h_in = 12'd1;
  logic [11:0]           w_in = 12'd1;
  logic                  rd_req_vld;
  logic                  rd_req_rdy = 1'b0;
  logic [AW-1:0]         rd_req_addr;
  logic [LOG2_BURST-1:0] rd_req_len;
  logic                  rd_fifo_pop = 1'b0;
  logic                  busy;
  logic                  done;

  softmax_rd_req #(
    .AW(AW), .AXI_BURST_LEN(AXI_BURST_LEN), .LOG2_BURST(LOG2_BURST),
    .TOUT(32), .MAX_DAT_DW(8), .FIFO_DEPTH(FIFO_DEPTH),
    .LOG2_CH(12), .LOG2_H(12), .LOG2_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .surface_stride(surface_stride), .line_stride(line_stride),
    .ch_in_div_tout(ch_in_div_tout), .h_in(h_in), .w_in(w_in),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_fifo_pop(rd_fifo_pop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [AW-1:0] q_addr[$];
  int unsigned   q_len[$];
  int            pending    = 0;
  int            pop_budget = 0;

  // Base sequence: h=1, w=20, 2 channel groups.
  logic [AW-1:0] exp_base_addr [12] = '{32'h1000, 32'h5000, 32'h1000, 32'h5000,
                                        32'h1000, 32'h5000, 32'h1200, 32'h5200,
                                        32'h1200, 32'h5200, 32'h1200, 32'h5200};
  int unsigned   exp_base_len  [12] = '{15, 15, 15, 15, 15, 15, 3, 3, 3, 3, 3, 3};
  // Multi-line sequence: h=2, w=16, 2 channel groups.
  logic [AW-1:0] exp_ml_addr   [12] = '{32'h1000, 32'h5000, 32'h1000, 32'h5000,
                                        32'h1000, 32'h5000, 32'h1800, 32'h5800,
                                        32'h1800, 32'h5800, 32'h1800, 32'h5800};

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(rd_fifo_pop && (dut.u_credit.credit_q == CW'(FIFO_DEPTH))))
    else $error("pop with credit already at FIFO depth");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Handshake recorder.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n && rd_req_vld && rd_req_rdy) begin
      q_addr.push_back(rd_req_addr);
      q_len.push_back(int'(rd_req_len));
      pending += int'(rd_req_len) + 1;
    end
  end

  // Response consumer: one pixel per cycle while budget and data remain.
  initial forever begin
    @(negedge clk);
    #2;
    if (pop_budget > 0 && pending > 0) begin
      rd_fifo_pop = 1'b1;
      pop_budget--;
      pending--;
    end else begin
      rd_fifo_pop = 1'b0;
    end
  end

  task automatic cfg(input logic [AW-1:0] b, input logic [11:0] ch,
                     input logic [11:0] h, input logic [11:0] w);
    base_addr      = b;
    surface_stride = 32'h4000;
    line_stride    = 32'h800;
    ch_in_div_tout = ch;
    h_in           = h;
    w_in           = w;
    q_addr.delete();
    q_len.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned max_cyc);
    int unsigned n = 0;
    bit seen = 1'b0;
    while (!seen && n < max_cyc) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_size(input int unsigned sz, input int unsigned max_cyc);
    int unsigned n = 0;
    while (q_addr.size() < sz && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_vld(input string tag, input int unsigned max_cyc);
    int unsigned n = 0;
    while (!rd_req_vld && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 64'(rd_req_vld), 64'd1);
  endtask

  task automatic check_seq(input string tag, input logic [AW-1:0] ea [12],
                           input int unsigned el [12]);
    check({tag, "_count"}, 64'(q_addr.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_addr[%0d]", tag, i),
            (i < q_addr.size()) ? 64'(q_addr[i]) : '1, 64'(ea[i]));
      check($sformatf("%s_len[%0d]", tag, i),
            (i < q_len.size()) ? 64'(q_len[i]) : '1, 64'(el[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vld"},  64'(rd_req_vld),  64'd0);
    check({tag, "_addr"}, 64'(rd_req_addr), 64'd0);
    check({tag, "_len"},  64'(rd_req_len),  64'd0);
    check({tag, "_busy"}, 64'(busy),        64'd0);
    check({tag, "_done"}, 64'(done),        64'd0);
  endtask

  task automatic run_base(input string tag);
    cfg(32'h1000, 12'd2, 12'd1, 12'd20);
    rd_req_rdy = 1'b1;
    pop_budget = 100000;
    pulse_start();
    check({tag, "_first_vld"},  64'(rd_req_vld),  64'd1);
    check({tag, "_first_addr"}, 64'(rd_req_addr), 64'h1000);
    check({tag, "_first_len"},  64'(rd_req_len),  64'd15);
    check({tag, "_busy"},       64'(busy),        64'd1);
    wait_done({tag, "_done"}, 1000);
    check({tag, "_drained"}, 64'(pending), 64'd0);
    check_seq(tag, exp_base_addr, exp_base_len);
  endtask

  initial begin
    int unsigned el15 [12] = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
    bit early_done;

    // Reset state.
    tick();
    tick();
    check_idle_outputs("rst");
    check("rst_credit", 64'(dut.u_credit.credit_q), 64'(FIFO_DEPTH));
    rst_n = 1'b1;
    tick();
    check_idle_outputs("post_rst");

    // Base sequence.
    run_base("base");

    // Credit stall: 12 full bursts, no pops.
    cfg(32'h1000, 12'd1, 12'd1, 12'd64);
    pop_budget = 0;
    rd_req_rdy = 1'b1;
    pulse_start();
    repeat (20) tick();
    check("stall_count", 64'(q_addr.size()), 64'd4);
    check("stall_vld", 64'(rd_req_vld), 64'd0);
    check("stall_credit", 64'(dut.u_credit.credit_q), 64'd0);
    pop_budget = 16;
    repeat (20) tick();
    check("stall_count_after_pops", 64'(q_addr.size()), 64'd5);
    check("stall_vld_after_pops", 64'(rd_req_vld), 64'd0);
    check("stall_req4_addr", (q_addr.size() > 4) ? 64'(q_addr[4]) : '1, 64'h1200);
    pop_budget = 100000;
    wait_done("stall_done", 1000);
    check("stall_total", 64'(q_addr.size()), 64'd12);
    check("stall_last_addr", (q_addr.size() == 12) ? 64'(q_addr[11]) : '1, 64'h1600);
    check("stall_last_len", (q_len.size() == 12) ? 64'(q_len[11]) : '1, 64'd15);

    // Backpressure on request 0 and on request 7.
    cfg(32'h1000, 12'd2, 12'd1, 12'd20);
    rd_req_rdy = 1'b0;
    pop_budget = 100000;
    pulse_start();
    wait_vld("bp0_vld_rise", 20);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp0_vld[%0d]", k), 64'(rd_req_vld), 64'd1);
      check($sformatf("bp0_addr[%0d]", k), 64'(rd_req_addr), 64'h1000);
      check($sformatf("bp0_len[%0d]", k), 64'(rd_req_len), 64'd15);
    end
    check("bp0_no_hs", 64'(q_addr.size()), 64'd0);
    rd_req_rdy = 1'b1;
    wait_size(7, 200);
    rd_req_rdy = 1'b0;
    wait_vld("bp7_vld_rise", 50);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp7_vld[%0d]", k), 64'(rd_req_vld), 64'd1);
      check($sformatf("bp7_addr[%0d]", k), 64'(rd_req_addr), 64'h5200);
      check($sformatf("bp7_len[%0d]", k), 64'(rd_req_len), 64'd3);
    end
    rd_req_rdy = 1'b1;
    wait_done("bp_done", 1000);
    check_seq("bp", exp_base_addr, exp_base_len);

    // Multi-line wrap; CSR change after start has no effect.
    cfg(32'h1000, 12'd2, 12'd2, 12'd16);
    rd_req_rdy = 1'b1;
    pop_budget = 100000;
    pulse_start();
    line_stride    = 32'h000D_EAD0;
    surface_stride = 32'h0000_0040;
    wait_done("ml_done", 1000);
    check_seq("ml", exp_ml_addr, el15);

    // Simultaneous handshake + pop, ignored start, done after final pop.
    cfg(32'h1000, 12'd1, 12'd1, 12'd16);
    rd_req_rdy = 1'b0;
    pop_budget = 0;
    pulse_start();
    check("sim_vld", 64'(rd_req_vld), 64'd1);
    check("sim_credit0", 64'(dut.u_credit.credit_q), 64'd64);
    start = 1'b1;
    rd_req_rdy = 1'b1;
    tick();
    start = 1'b0;
    rd_req_rdy = 1'b0;
    check("sim_credit1", 64'(dut.u_credit.credit_q), 64'd48);
    rd_req_rdy = 1'b1;
    pop_budget = 1;
    tick();
    rd_req_rdy = 1'b0;
    check("sim_credit_net", 64'(dut.u_credit.credit_q), 64'd33);
    check("sim_busy", 64'(busy), 64'd1);
    rd_req_rdy = 1'b1;
    early_done = 1'b0;
    repeat (10) begin
      tick();
      if (done) early_done = 1'b1;
    end
    check("sim_issued", 64'(q_addr.size()), 64'd3);
    check("sim_addr2", (q_addr.size() > 2) ? 64'(q_addr[2]) : '1, 64'h1000);
    pop_budget = pending - 1;
    repeat (60) begin
      tick();
      if (done) early_done = 1'b1;
    end
    check("sim_no_early_done", 64'(early_done), 64'd0);
    check("sim_busy_drain", 64'(busy), 64'd1);
    check("sim_credit_last", 64'(dut.u_credit.credit_q), 64'd63);
    pop_budget = 1;
    tick();
    check("sim_done_pulse", 64'(done), 64'd1);
    check("sim_idle_busy", 64'(busy), 64'd0);
    tick();
    check("sim_done_once", 64'(done), 64'd0);
    check("sim_no_restart", 64'(q_addr.size()), 64'd3);

    // Reset mid-frame, then a clean rerun.
    cfg(32'h1000, 12'd2, 12'd1, 12'd20);
    rd_req_rdy = 1'b1;
    pop_budget = 100000;
    pulse_start();
    wait_size(3, 50);
    rst_n = 1'b0;
    pending = 0;
    pop_budget = 0;
    #1;
    check_idle_outputs("midrst");
    tick();
    tick();
    check("midrst_credit", 64'(dut.u_credit.credit_q), 64'(FIFO_DEPTH));
    rst_n = 1'b1;
    tick();
    check_idle_outputs("midrst_rel");
    run_base("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
